// File: rtl/jogador_pkg.sv
// Shared types and constants for the autonomous memory-game player.
// The new-element generator source depends on JOGADOR_LFSR_EN (see jogador_automatico).
package jogador_pkg;

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        INICIA         = 4'd1,
        ESPERA         = 4'd2,
        ACESO          = 4'd3,
        SILENCIO       = 4'd4,
        PRESSIONA      = 4'd5,
        SOLTA          = 4'd6,
        NOVO_PRESSIONA = 4'd7,
        NOVO_SOLTA     = 4'd8,
        FIM            = 4'd9
    } estado_t;

    localparam logic [3:0] LFSR_SEED = 4'b1001;
    localparam logic [3:0] ROT_RESET = 4'b0001;

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Fibonacci LFSR for x^4 + x^3 + 1.
    function automatic logic [3:0] lfsr_prox(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [3:0] rot_prox(input logic [3:0] s);
        return {s[2:0], s[3]};
    endfunction

endpackage

// File: rtl/jogador_memoria.sv
// Sequence store: synchronous write, asynchronous read, no reset.
module jogador_memoria #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr_w,
    input  logic [AW-1:0] addr_r,
    input  logic [3:0]    din,
    output logic [3:0]    dout
);

    logic [3:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr_w] <= din;
        end
    end

    assign dout = mem_q[addr_r];

endmodule

// File: rtl/jogador_automatico.sv
// Autonomous player: captures the game's leds sequence, replays it on botoes and appends a new element.
// Define JOGADOR_LFSR_EN to draw the new element from a 4-bit LFSR instead of a rotating one-hot.
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned T_PRESS = 1000,
    parameter int unsigned T_GAP   = 1000,
    parameter int unsigned T_QUIET = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       concluido,
    output logic       resultado,
    output logic       erro_captura,
    output logic [3:0] db_estado,
    output logic [3:0] db_tamanho
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned NW    = AW + 1;
    localparam int unsigned T_PG  = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
    localparam int unsigned T_MAX = (T_PG > T_QUIET) ? T_PG : T_QUIET;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    estado_t       estado_q;
    logic [NW-1:0] tamanho_q;
    logic [AW-1:0] idx_q;
    logic [TW-1:0] cnt_q;
    logic [3:0]    gen_q;
    logic          jogar_q;
    logic [3:0]    botoes_q;
    logic          concluido_q;
    logic          resultado_q;
    logic          erro_q;

    logic          fim_jogo_c;
    logic          captura_c;
    logic          cheio_c;
    logic          we_c;
    logic          ultimo_c;
    logic [AW-1:0] addr_r_c;
    logic [3:0]    dout_c;
    logic [3:0]    novo_c;
    logic [3:0]    gen_d;
    logic [3:0]    gen_reset_c;

`ifdef JOGADOR_LFSR_EN
    assign gen_reset_c = LFSR_SEED;
    assign gen_d       = lfsr_prox(gen_q);
    assign novo_c      = 4'b0001 << gen_q[1:0];
`else
    assign gen_reset_c = ROT_RESET;
    assign gen_d       = rot_prox(gen_q);
    assign novo_c      = gen_q;
`endif

    assign fim_jogo_c = (ganhou || perdeu) && (estado_q != OCIOSO) && (estado_q != FIM);
    assign captura_c  = ((estado_q == ESPERA) || (estado_q == SILENCIO)) && (leds != 4'b0000);
    assign cheio_c    = (tamanho_q == NW'(DEPTH));
    assign we_c       = captura_c && !cheio_c && !fim_jogo_c;
    assign ultimo_c   = (NW'(idx_q) == (tamanho_q - NW'(1)));
    // Look ahead to the element the next PRESSIONA will drive, so botoes is valid on entry.
    assign addr_r_c   = (estado_q == SOLTA) ? AW'(idx_q + AW'(1)) : '0;

    jogador_memoria #(
        .DEPTH (DEPTH)
    ) u_memoria (
        .clock  (clock),
        .we     (we_c),
        .addr_w (AW'(tamanho_q)),
        .addr_r (addr_r_c),
        .din    (leds),
        .dout   (dout_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            tamanho_q   <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            gen_q       <= gen_reset_c;
            jogar_q     <= 1'b0;
            botoes_q    <= 4'b0000;
            concluido_q <= 1'b0;
            resultado_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            jogar_q <= 1'b0;
            if (fim_jogo_c) begin
                estado_q    <= FIM;
                resultado_q <= ganhou;
                concluido_q <= 1'b1;
                botoes_q    <= 4'b0000;
            end else begin
                unique case (estado_q)
                    OCIOSO, FIM: begin
                        if (iniciar) begin
                            estado_q    <= INICIA;
                            jogar_q     <= 1'b1;
                            concluido_q <= 1'b0;
                            erro_q      <= 1'b0;
                            tamanho_q   <= '0;
                        end
                    end
                    INICIA: begin
                        tamanho_q <= '0;
                        estado_q  <= ESPERA;
                    end
                    ESPERA, SILENCIO: begin
                        if (captura_c) begin
                            if (!cheio_c) begin
                                tamanho_q <= tamanho_q + NW'(1);
                            end
                            if (cheio_c || !eh_one_hot(leds)) begin
                                erro_q <= 1'b1;
                            end
                            estado_q <= ACESO;
                        end else if (estado_q == SILENCIO) begin
                            // An empty capture never times out; it waits for the next leds event.
                            if (cnt_q == TW'(T_QUIET - 1)) begin
                                if (tamanho_q != '0) begin
                                    estado_q <= PRESSIONA;
                                    idx_q    <= '0;
                                    cnt_q    <= '0;
                                    botoes_q <= dout_c;
                                end
                            end else begin
                                cnt_q <= cnt_q + TW'(1);
                            end
                        end
                    end
                    ACESO: begin
                        if (leds == 4'b0000) begin
                            estado_q <= SILENCIO;
                            cnt_q    <= '0;
                        end
                    end
                    PRESSIONA, NOVO_PRESSIONA: begin
                        if (cnt_q == TW'(T_PRESS - 1)) begin
                            estado_q <= (estado_q == PRESSIONA) ? SOLTA : NOVO_SOLTA;
                            botoes_q <= 4'b0000;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
                    end
                    SOLTA: begin
                        if (cnt_q == TW'(T_GAP - 1)) begin
                            cnt_q <= '0;
                            if (ultimo_c) begin
                                estado_q <= NOVO_PRESSIONA;
                                botoes_q <= novo_c;
                            end else begin
                                estado_q <= PRESSIONA;
                                idx_q    <= idx_q + AW'(1);
                                botoes_q <= dout_c;
                            end
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
                    end
                    NOVO_SOLTA: begin
                        if (cnt_q == TW'(T_GAP - 1)) begin
                            cnt_q     <= '0;
                            gen_q     <= gen_d;
                            tamanho_q <= '0;
                            estado_q  <= ESPERA;
                        end else begin
                            cnt_q <= cnt_q + TW'(1);
                        end
                    end
                    default: begin
                        estado_q <= OCIOSO;
                        botoes_q <= 4'b0000;
                    end
                endcase
            end
        end
    end

    assign jogar        = jogar_q;
    assign botoes       = botoes_q;
    assign concluido    = concluido_q;
    assign resultado    = resultado_q;
    assign erro_captura = erro_q;
    assign db_estado    = 4'(estado_q);
    assign db_tamanho   = 4'(tamanho_q);

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: expected presses are queued as leds are shown
// and checked as botoes is produced; follows JOGADOR_LFSR_EN for the new-element model.
module tb_jogador_automatico;

    localparam int unsigned T_PRESS = 4;
    localparam int unsigned T_GAP   = 3;
    localparam int unsigned T_QUIET = 10;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] leds;
    logic       ganhou;
    logic       perdeu;
    logic       jogar;
    logic [3:0] botoes;
    logic       concluido;
    logic       resultado;
    logic       erro_captura;
    logic [3:0] db_estado;
    logic [3:0] db_tamanho;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] gen_m;
    bit         mon_en = 1'b1;
    int         run_press = 0;
    int         run_gap   = 0;

    jogador_automatico #(
        .DEPTH   (16),
        .T_PRESS (T_PRESS),
        .T_GAP   (T_GAP),
        .T_QUIET (T_QUIET)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .leds         (leds),
        .ganhou       (ganhou),
        .perdeu       (perdeu),
        .jogar        (jogar),
        .botoes       (botoes),
        .concluido    (concluido),
        .resultado    (resultado),
        .erro_captura (erro_captura),
        .db_estado    (db_estado),
        .db_tamanho   (db_tamanho)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent new-element model.
    function automatic logic [3:0] novo_m(input logic [3:0] g);
`ifdef JOGADOR_LFSR_EN
        logic [3:0] um = 4'b0001;
        return um << g[1:0];
`else
        return g;
`endif
    endfunction

    function automatic logic [3:0] gen_prox_m(input logic [3:0] g);
`ifdef JOGADOR_LFSR_EN
        return {g[2:0], g[3] ^ g[2]};
`else
        return {g[2:0], g[3]};
`endif
    endfunction

    // Press monitor: value at press start, press length, and gap length.
    always @(negedge clock) begin
        if (reset) begin
            run_press = 0;
            run_gap   = 0;
        end else begin
            if (botoes != 4'b0000) begin
                if (run_press == 0 && mon_en) begin
                    if (exp_q.size() == 0) chk("press_unexpected", 32'(botoes), 32'h0);
                    else                   chk("press_value", 32'(botoes), 32'(exp_q.pop_front()));
                end
                run_press++;
            end else begin
                if (run_press != 0 && mon_en && db_estado != 4'd9)
                    chk("press_len", 32'(run_press), 32'(T_PRESS));
                run_press = 0;
            end
            if (db_estado == 4'd6 || db_estado == 4'd8) begin
                run_gap++;
            end else begin
                if (run_gap != 0 && mon_en && db_estado != 4'd9)
                    chk("gap_len", 32'(run_gap), 32'(T_GAP));
                run_gap = 0;
            end
        end
    end

    task automatic wait_state(input logic [3:0] e, input int lim, input string tag);
        int k = 0;
        while (db_estado !== e && k < lim) begin
            @(negedge clock);
            k++;
        end
        chk(tag, 32'(db_estado), 32'(e));
    endtask

    task automatic show(input logic [3:0] v);
        leds = v;
        repeat (5) @(negedge clock);
        leds = 4'b0000;
    endtask

    // One full round: display n items, expect their replay plus the generated element.
    task automatic rodada(input int n, input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2);
        logic [3:0] v [3];
        int k;
        v[0] = v0; v[1] = v1; v[2] = v2;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v[i]);
            show(v[i]);
            if (i < n - 1) repeat (3) @(negedge clock);
        end
        exp_q.push_back(novo_m(gen_m));
        // leds falls before edge e0; the first press is registered at e0 + T_QUIET.
        k = 0;
        while (botoes == 4'b0000 && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("first_press_latency", 32'(k), 32'(T_QUIET + 1));
        chk("db_tamanho_replay", 32'(db_tamanho), 32'(n));
        wait_state(4'd2, 200, "round_back_to_espera");
        chk("db_tamanho_restart", 32'(db_tamanho), 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        gen_m = gen_prox_m(gen_m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef JOGADOR_LFSR_EN
        gen_m = 4'b1001;
`else
        gen_m = 4'b0001;
`endif
        reset   = 1'b1;
        iniciar = 1'b0;
        leds    = 4'b0000;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_estado", 32'(db_estado), 32'h0);
        chk("rst_botoes", 32'(botoes), 32'h0);
        chk("rst_flags", 32'({jogar, concluido, resultado, erro_captura}), 32'h0);
        chk("rst_tamanho", 32'(db_tamanho), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        iniciar = 1'b1;
        @(negedge clock);
        chk("jogar_pulse", 32'(jogar), 32'h1);
        chk("estado_inicia", 32'(db_estado), 32'h1);
        iniciar = 1'b0;
        @(negedge clock);
        chk("jogar_one_cycle", 32'(jogar), 32'h0);
        chk("estado_espera", 32'(db_estado), 32'h2);
        chk("botoes_idle", 32'(botoes), 32'h0);

        rodada(2, 4'b0010, 4'b1000, 4'b0000);
        rodada(3, 4'b0100, 4'b0001, 4'b1000);
        chk("erro_clean", 32'(erro_captura), 32'h0);
        rodada(1, 4'b0110, 4'b0000, 4'b0000);
        chk("erro_multihot", 32'(erro_captura), 32'h1);
        rodada(1, 4'b0001, 4'b0000, 4'b0000);

        // Loss during a press.
        mon_en = 1'b0;
        show(4'b0100);
        wait_state(4'd5, 50, "reach_pressiona");
        perdeu = 1'b1;
        @(negedge clock);
        perdeu = 1'b0;
        chk("loss_estado", 32'(db_estado), 32'h9);
        chk("loss_botoes", 32'(botoes), 32'h0);
        chk("loss_concluido", 32'(concluido), 32'h1);
        chk("loss_resultado", 32'(resultado), 32'h0);
        chk("loss_erro_sticky", 32'(erro_captura), 32'h1);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        chk("restart_estado", 32'(db_estado), 32'h1);
        chk("restart_jogar", 32'(jogar), 32'h1);
        chk("restart_clears", 32'({concluido, erro_captura}), 32'h0);
        @(negedge clock);

        // Win and loss together during a gap: win takes precedence.
        show(4'b1000);
        wait_state(4'd6, 60, "reach_solta");
        ganhou = 1'b1;
        perdeu = 1'b1;
        @(negedge clock);
        ganhou = 1'b0;
        perdeu = 1'b0;
        chk("both_estado", 32'(db_estado), 32'h9);
        chk("both_resultado", 32'(resultado), 32'h1);
        chk("both_concluido", 32'(concluido), 32'h1);
        chk("both_botoes", 32'(botoes), 32'h0);
        repeat (3) @(negedge clock);
        chk("fim_holds", 32'(db_estado), 32'h9);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
